// File: rtl/pri_sel_rr_pipe.sv
// pri_sel_rr_pipe: two-stage pipelined N-way max-priority selector with
// round-robin tie-break.
//   clk, rst_n          clock / async active-low reset
//   in_valid/in_ready   input handshake; in[0:N-1] are W-bit priorities, 0 = idle
//   out_valid/out_ready output handshake
//   out_pri             max priority of the transaction
//   out_idx/out_grant   selected input (index / one-hot), zero when out_none
//   out_none            no input was requesting
// Stage A holds {max, candidate mask}; stage B holds the same for the output.
// The RR search runs combinationally on stage B so ptr updates only on a
// real output handshake.

// Per-lane candidate compare: lane is a candidate when it requests at the max.
module pri_sel_lane #(
  parameter int W = 4
) (
  input  logic [W-1:0] pri,
  input  logic [W-1:0] mx,
  output logic         cand
);
  assign cand = (pri == mx) && (pri != '0);
endmodule

module pri_sel_rr_pipe #(
  parameter  int N  = 8,
  parameter  int P  = 16,
  localparam int W  = $clog2(P),
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in [0:N-1],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_pri,
  output logic [IW-1:0] out_idx,
  output logic [N-1:0]  out_grant,
  output logic          out_none
);
  localparam int STAGES = 2;
  localparam int NP     = 1 << $clog2(N);

  typedef struct packed {
    logic [W-1:0] mx;
    logic [N-1:0] cand;
  } stg_t;

  // Max reduction as a heap-indexed binary tree: leaves at NP..2NP-1, root at 1.
  // Leaves beyond N are tied to 0 so non-power-of-two N works.
  logic [W-1:0] hp [1:2*NP-1];

  for (genvar i = 0; i < NP; i++) begin : g_leaf
    if (i < N) begin : g_in
      assign hp[NP+i] = in[i];
    end else begin : g_pad
      assign hp[NP+i] = '0;
    end
  end

  for (genvar k = 1; k < NP; k++) begin : g_node
    assign hp[k] = (hp[2*k] > hp[2*k+1]) ? hp[2*k] : hp[2*k+1];
  end

  logic [N-1:0] lc;
  for (genvar i = 0; i < N; i++) begin : g_lane
    pri_sel_lane #(.W(W)) u_lane (
      .pri  (in[i]),
      .mx   (hp[1]),
      .cand (lc[i])
    );
  end

  stg_t              stg_a, stg_b;
  logic [STAGES:1]   vld_pipe;   // [1] = stage A valid, [2] = stage B valid
  logic [IW-1:0]     ptr;

  logic b_pop, a_mv, acc;
  assign b_pop    = vld_pipe[2] && out_ready;
  assign a_mv     = vld_pipe[1] && (!vld_pipe[2] || b_pop);
  assign in_ready = !vld_pipe[1] || a_mv;
  assign acc      = in_valid && in_ready;

  // Cyclic first-set search over stage B candidates starting at ptr.
  logic [IW-1:0] sel;
  logic          found;
  int            j;
  always_comb begin
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && stg_b.cand[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
  end

  assign out_valid = vld_pipe[2];
  assign out_pri   = stg_b.mx;
  assign out_idx   = sel;
  // Gated by B valid so the reset state reads out_none = 0.
  assign out_none  = vld_pipe[2] && !found;
  assign out_grant = found ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;

  logic [IW-1:0] nxt_ptr;
  assign nxt_ptr = (sel == IW'(N-1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_a    <= '0;
      stg_b    <= '0;
      vld_pipe <= '0;
      ptr      <= '0;
    end else begin
      if (acc)  stg_a <= '{mx: hp[1], cand: lc};
      if (a_mv) stg_b <= stg_a;
      if (acc)       vld_pipe[1] <= 1'b1;
      else if (a_mv) vld_pipe[1] <= 1'b0;
      if (a_mv)       vld_pipe[2] <= 1'b1;
      else if (b_pop) vld_pipe[2] <= 1'b0;
      if (b_pop && found) ptr <= nxt_ptr;
    end
  end
endmodule

// File: tb/tb_pri_sel_rr_pipe.sv
module tb_pri_sel_rr_pipe;
  typedef logic [7:0][3:0] vec_t;
  typedef struct packed {
    logic [3:0] pri;
    logic [2:0] idx;
    logic       none;
  } exp_t;
  typedef struct {
    vec_t v;
    exp_t e;
  } tv_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // N=8, P=16 instance
  logic       iv8, ir8, ov8, or8, on8;
  logic [3:0] in8 [0:7];
  logic [3:0] op8;
  logic [2:0] oi8;
  logic [7:0] og8;
  // N=5, P=4 instance
  logic       iv5, ir5, ov5, or5, on5;
  logic [1:0] in5 [0:4];
  logic [1:0] op5;
  logic [2:0] oi5;
  logic [4:0] og5;

  pri_sel_rr_pipe #(.N(8), .P(16)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in(in8),
    .out_valid(ov8), .out_ready(or8), .out_pri(op8), .out_idx(oi8),
    .out_grant(og8), .out_none(on8)
  );
  pri_sel_rr_pipe #(.N(5), .P(4)) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(ir5), .in(in5),
    .out_valid(ov5), .out_ready(or5), .out_pri(op5), .out_idx(oi5),
    .out_grant(og5), .out_none(on5)
  );

  int   ncmp = 0, nerr = 0;
  int   mp8 = 0, mp5 = 0;
  exp_t q8[$], q5[$];
  exp_t e8, e5;
  tv_t  tbl8[9];
  tv_t  tbl5[6];

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(int a0, int a1, int a2, int a3,
                               int a4, int a5, int a6, int a7);
    vec_t r;
    r[0] = 4'(a0); r[1] = 4'(a1); r[2] = 4'(a2); r[3] = 4'(a3);
    r[4] = 4'(a4); r[5] = 4'(a5); r[6] = 4'(a6); r[7] = 4'(a7);
    return r;
  endfunction

  function automatic exp_t mkexp(int p, int i, bit n);
    exp_t r;
    r.pri = 4'(p); r.idx = 3'(i); r.none = n;
    return r;
  endfunction

  // Reference: plain max, then cyclic scan from p for the first lane at max.
  function automatic exp_t mdl(vec_t v, int n, int p);
    exp_t r;
    int   mx;
    r  = '0;
    mx = 0;
    for (int i = 0; i < n; i++) if (int'(v[i]) > mx) mx = int'(v[i]);
    if (mx == 0) begin
      r.none = 1'b1;
      return r;
    end
    r.pri = 4'(mx);
    for (int k = 0; k < n; k++) begin
      int jj;
      jj = (p + k) % n;
      if (int'(v[jj]) == mx) begin
        r.idx = 3'(jj);
        return r;
      end
    end
    return r;
  endfunction

  task automatic push(input int sel, input vec_t v, input bit use_e, input exp_t e);
    exp_t x;
    x = use_e ? e : mdl(v, (sel == 0) ? 8 : 5, (sel == 0) ? mp8 : mp5);
    if (sel == 0) begin
      q8.push_back(x);
      if (!x.none) mp8 = (int'(x.idx) + 1) % 8;
    end else begin
      q5.push_back(x);
      if (!x.none) mp5 = (int'(x.idx) + 1) % 5;
    end
  endtask

  // Call just after a rising edge; returns just after the edge that accepted.
  task automatic send(input int sel, input vec_t v, input bit use_e, input exp_t e);
    bit ok;
    ok = 1'b0;
    if (sel == 0) begin
      for (int i = 0; i < 8; i++) in8[i] = v[i];
      iv8 = 1'b1;
    end else begin
      for (int i = 0; i < 5; i++) in5[i] = v[i][1:0];
      iv5 = 1'b1;
    end
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge clk);
      if ((sel == 0) ? ir8 : ir5) ok = 1'b1;
    end
    if (!ok) begin
      ncmp++; nerr++;
      $display("FAIL send_timeout: dut %0d in_ready stuck low, got 0 expected 1", sel);
    end else begin
      push(sel, v, use_e, e);
    end
    @(posedge clk); #1;
    if (sel == 0) iv8 = 1'b0; else iv5 = 1'b0;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((q8.size() != 0 || q5.size() != 0) && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk("drain_q8_left", q8.size(), 0);
    chk("drain_q5_left", q5.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic rchk(input string t);
    chk({t, "_ov8"}, ov8, 0);  chk({t, "_ir8"}, ir8, 1);
    chk({t, "_op8"}, op8, 0);  chk({t, "_oi8"}, oi8, 0);
    chk({t, "_og8"}, og8, 0);  chk({t, "_on8"}, on8, 0);
    chk({t, "_ov5"}, ov5, 0);  chk({t, "_ir5"}, ir5, 1);
    chk({t, "_og5"}, og5, 0);  chk({t, "_on5"}, on5, 0);
  endtask

  // Scoreboard pop on every output handshake.
  always @(negedge clk) begin
    if (rst_n && ov8 && or8) begin
      if (q8.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL u8_extra_out: got output idx %0d expected none", oi8);
      end else begin
        e8 = q8.pop_front();
        chk("u8_pri", op8, e8.pri);
        chk("u8_idx", oi8, e8.idx);
        chk("u8_none", on8, e8.none);
        chk("u8_grant", og8, e8.none ? 0 : (1 << e8.idx));
      end
    end
    if (rst_n && ov5 && or5) begin
      if (q5.size() == 0) begin
        ncmp++; nerr++;
        $display("FAIL u5_extra_out: got output idx %0d expected none", oi5);
      end else begin
        e5 = q5.pop_front();
        chk("u5_pri", op5, e5.pri);
        chk("u5_idx", oi5, e5.idx);
        chk("u5_none", on5, e5.none);
        chk("u5_grant", og5, e5.none ? 0 : (1 << e5.idx));
      end
    end
  end

  vec_t tie, v, bp[5];
  int   acc_n;
  logic [3:0] sp;
  logic [2:0] si;
  logic [7:0] sg;
  logic       sn;
  bit   d5, d8;

  initial begin
    tie = mkv(3, 9, 2, 9, 0, 1, 9, 4);
    tbl8[0] = '{tie, mkexp(9, 1, 0)};
    tbl8[1] = '{tie, mkexp(9, 3, 0)};
    tbl8[2] = '{tie, mkexp(9, 6, 0)};
    tbl8[3] = '{tie, mkexp(9, 1, 0)};
    tbl8[4] = '{mkv(0, 0, 0, 0, 0, 0, 0, 5), mkexp(5, 7, 0)};
    tbl8[5] = '{mkv(0, 0, 0, 0, 0, 0, 0, 0), mkexp(0, 0, 1)};
    tbl8[6] = '{tie, mkexp(9, 1, 0)};
    tbl8[7] = '{mkv(15, 14, 14, 14, 14, 15, 14, 14), mkexp(15, 5, 0)};
    tbl8[8] = '{mkv(0, 0, 15, 0, 0, 0, 0, 0), mkexp(15, 2, 0)};
    for (int i = 0; i < 6; i++)
      tbl5[i] = '{mkv(3, 3, 3, 3, 3, 0, 0, 0), mkexp(3, i % 5, 0)};
    bp[0] = mkv(6, 0, 0, 6, 0, 6, 0, 0);
    bp[1] = mkv(0, 8, 0, 0, 8, 0, 0, 8);
    bp[2] = mkv(1, 2, 3, 4, 5, 6, 7, 8);
    bp[3] = mkv(2, 2, 2, 2, 2, 2, 2, 2);
    bp[4] = mkv(9, 0, 0, 0, 0, 0, 0, 9);

    rst_n = 1'b0;
    iv8 = 1'b0; iv5 = 1'b0; or8 = 1'b1; or5 = 1'b1;
    for (int i = 0; i < 8; i++) in8[i] = '0;
    for (int i = 0; i < 5; i++) in5[i] = '0;
    #23;
    rchk("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back table run on N=8.
    for (int i = 0; i < 9; i++) send(0, tbl8[i].v, 1'b1, tbl8[i].e);
    drain();

    // Backpressure: out_ready low for 5 cycles with in_valid held high.
    or8 = 1'b0;
    acc_n = 0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < 8; i++) in8[i] = bp[c][i];
      iv8 = 1'b1;
      @(negedge clk);
      chk("bp_in_ready", ir8, (c < 2) ? 1 : 0);
      if (ir8) begin
        push(0, bp[c], 1'b0, '0);
        acc_n++;
      end
      if (c >= 2) chk("bp_out_valid", ov8, 1);
      if (c == 2) begin
        sp = op8; si = oi8; sg = og8; sn = on8;
      end else if (c > 2) begin
        chk("bp_hold_pri", op8, sp);
        chk("bp_hold_idx", oi8, si);
        chk("bp_hold_grant", og8, sg);
        chk("bp_hold_none", on8, sn);
      end
      @(posedge clk); #1;
    end
    iv8 = 1'b0;
    chk("bp_accepted", acc_n, 2);
    or8 = 1'b1;
    drain();

    // Mid-stream async reset with both stages full.
    or8 = 1'b0;
    send(0, tie, 1'b0, '0);
    send(0, bp[1], 1'b0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    rchk("midrst");
    q8.delete(); q5.delete();
    mp8 = 0; mp5 = 0;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    or8 = 1'b1;
    @(posedge clk); #1;
    send(0, tbl8[0].v, 1'b1, tbl8[0].e);  // ptr must restart at 0
    drain();

    // N=5 all-tie rotation.
    for (int i = 0; i < 6; i++) send(1, tbl5[i].v, 1'b1, tbl5[i].e);
    drain();

    // Random stress: both instances, random gaps and random out_ready.
    d5 = 1'b0; d8 = 1'b0;
    fork
      begin
        vec_t r5;
        for (int t = 0; t < 10000; t++) begin
          r5 = '0;
          for (int i = 0; i < 5; i++) r5[i] = 4'($urandom_range(0, 3));
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          send(1, r5, 1'b0, '0);
        end
        d5 = 1'b1;
      end
      begin
        vec_t r8;
        int   hi;
        for (int t = 0; t < 4000; t++) begin
          hi = ($urandom_range(0, 1) != 0) ? 3 : 15;
          r8 = '0;
          if (t % 37 != 0)
            for (int i = 0; i < 8; i++) r8[i] = 4'($urandom_range(0, hi));
          if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
          send(0, r8, 1'b0, '0);
        end
        d8 = 1'b1;
      end
      begin
        while (!(d5 && d8)) begin
          @(posedge clk); #1;
          or8 = 1'($urandom_range(0, 1));
          or5 = 1'($urandom_range(0, 1));
        end
        or8 = 1'b1; or5 = 1'b1;
      end
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
